// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_reader
// Description : Read-side engine for the MAC datapath sync FIFO. Drains a FIFO
//               with a 1-cycle registered read latency into a 2-entry output
//               buffer and presents the words as a valid/ready stream at up to
//               one word per cycle. m_last_o marks the final beat of each burst.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in   rising-edge clock
//   rst_n           in   asynchronous active-low reset
//   flush_i         in   synchronous flush of buffer, in-flight read, beat count
//   fifo_empty_i    in   FIFO empty flag
//   fifo_rd_en_o    out  FIFO read strobe (combinational from m_ready_i)
//   fifo_rd_data_i  in   FIFO read data, valid the cycle after the read strobe
//   m_valid_o       out  output word valid
//   m_ready_i       in   downstream accept
//   m_data_o        out  output word (buffer head)
//   m_last_o        out  current word is the last beat of its burst
// ============================================================================
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o
);

  localparam int             BCW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_LEN - 1);

  logic [1:0]            cnt;       // words held in the output buffer (0..2)
  logic                  inflight;  // a read issued last cycle returns this edge
  logic                  active;    // low for the first cycle out of reset
  logic [BCW-1:0]        beat_cnt;
  logic [DATA_WIDTH-1:0] buf0;      // head entry
  logic [DATA_WIDTH-1:0] buf1;      // second entry

  logic                  pop;
  logic                  push;
  logic [1:0]            occ;
  logic [1:0]            room_used;
  logic [1:0]            wr_pos;

  assign pop       = m_valid_o & m_ready_i;
  assign push      = inflight;
  assign occ       = cnt + {1'b0, inflight};
  // Occupancy as it will be after this cycle's pop; a new read is only safe
  // while fewer than two slots are committed.
  assign room_used = occ - {1'b0, pop};
  // Slot the returning word lands in, after the head has shifted on a pop.
  assign wr_pos    = cnt - {1'b0, pop};

  // The read strobe is gated by a registered flag so it stays low while reset
  // is asserted, independent of the FIFO flag.
  assign fifo_rd_en_o = active & ~flush_i & ~fifo_empty_i & (room_used < 2'd2);

  assign m_valid_o = (cnt != 2'd0);
  assign m_data_o  = buf0;
  assign m_last_o  = m_valid_o & (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      inflight <= 1'b0;
      cnt      <= 2'd0;
      beat_cnt <= '0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      active   <= 1'b1;
      // Read strobe is forced low during flush, so this also clears inflight.
      inflight <= fifo_rd_en_o;
      if (flush_i) begin
        // Returning word (if any) is dropped; buffered words are discarded.
        cnt      <= 2'd0;
        beat_cnt <= '0;
      end else begin
        cnt <= cnt + {1'b0, push} - {1'b0, pop};
        if (pop) begin
          buf0     <= buf1;
          beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BCW'(1);
        end
        // Placed after the shift so a simultaneous push wins the head slot.
        if (push) begin
          if (wr_pos == 2'd0) begin
            buf0 <= fifo_rd_data_i;
          end else begin
            buf1 <= fifo_rd_data_i;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
